// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the three-master memory bus arbiter: FSM states,
// master indices and the "no owner" grant value.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWN    = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  localparam logic [1:0] ARB_M_DATA  = 2'd0;
  localparam logic [1:0] ARB_M_FETCH = 2'd1;
  localparam logic [1:0] ARB_M_AUX   = 2'd2;
  localparam logic [1:0] ARB_NONE    = 2'b11;

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational winner select: M0 > M1 > M2, except a starving M1 beats M0.
// M2 is only eligible when the auxiliary master is enabled.
module arb_pick
  import bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  input  logic       aux_en,
  output logic [1:0] winner
);

  always_comb begin
    winner = ARB_NONE;
    if (req[ARB_M_FETCH] && (starve || !req[ARB_M_DATA])) begin
      winner = ARB_M_FETCH;
    end else if (req[ARB_M_DATA]) begin
      winner = ARB_M_DATA;
    end else if (req[ARB_M_AUX] && aux_en) begin
      winner = ARB_M_AUX;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master arbiter for the shared 32-bit memory bus, with a starvation
// guard for instruction fetch and a lock for atomic SWP / LDM/STM sequences.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AUX_EN     = 1,
  localparam int CNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      m0_addr,
  input  logic             m0_rd_req,
  input  logic             m0_wr_req,
  input  logic [31:0]      m0_wr_data,
  input  logic             m0_lock,
  output logic             m0_rw_wait,
  output logic [31:0]      m0_rd_data,
  input  logic [31:0]      m1_addr,
  input  logic             m1_rd_req,
  input  logic             m1_wr_req,
  input  logic [31:0]      m1_wr_data,
  input  logic             m1_lock,
  output logic             m1_rw_wait,
  output logic [31:0]      m1_rd_data,
  input  logic [31:0]      m2_addr,
  input  logic             m2_rd_req,
  input  logic             m2_wr_req,
  input  logic [31:0]      m2_wr_data,
  input  logic             m2_lock,
  output logic             m2_rw_wait,
  output logic [31:0]      m2_rd_data,
  output logic [31:0]      busaddr,
  output logic             rd_req,
  output logic             wr_req,
  output logic [31:0]      wr_data,
  input  logic             rw_wait,
  input  logic [31:0]      rd_data,
  output logic [1:0]       grant,
  output arb_state_e       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic             AUX_ON  = (AUX_EN != 0);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [2:0]  req;
  logic        own0, own1, own2;
  logic        own_rd, own_wr, own_lock, own_req;
  logic [31:0] own_addr, own_wdata;
  logic        done, m0_done, starve, rearb;
  logic [1:0]  winner;

  assign req = {m2_rd_req | m2_wr_req, m1_rd_req | m1_wr_req, m0_rd_req | m0_wr_req};

  // Only the registered grant selects the master, so a non-owner can never
  // put a strobe on the slave.
  assign own0 = (state_q != ARB_IDLE) && (grant_q == ARB_M_DATA);
  assign own1 = (state_q != ARB_IDLE) && (grant_q == ARB_M_FETCH);
  assign own2 = (state_q != ARB_IDLE) && (grant_q == ARB_M_AUX) && AUX_ON;

  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    if (own0) begin
      own_rd = m0_rd_req; own_wr = m0_wr_req; own_lock = m0_lock;
      own_addr = m0_addr; own_wdata = m0_wr_data;
    end else if (own1) begin
      own_rd = m1_rd_req; own_wr = m1_wr_req; own_lock = m1_lock;
      own_addr = m1_addr; own_wdata = m1_wr_data;
    end else if (own2) begin
      own_rd = m2_rd_req; own_wr = m2_wr_req; own_lock = m2_lock;
      own_addr = m2_addr; own_wdata = m2_wr_data;
    end
  end

  // Handshake: a master holds addr/strobe/data while its rw_wait is 1; a
  // transfer completes on the cycle its request is high and rw_wait is 0.
  assign own_req = own_rd | own_wr;
  assign done    = own_req & ~rw_wait;
  assign m0_done = done & own0;

  assign busaddr = own_addr;
  assign rd_req  = own_rd;
  assign wr_req  = own_wr & ~own_rd;
  assign wr_data = own_wdata;

  assign m0_rw_wait = own0 ? rw_wait : 1'b1;
  assign m1_rw_wait = own1 ? rw_wait : 1'b1;
  assign m2_rw_wait = own2 ? rw_wait : 1'b1;
  assign m0_rd_data = own0 ? rd_data : '0;
  assign m1_rd_data = own1 ? rd_data : '0;
  assign m2_rd_data = own2 ? rd_data : '0;

  // Starve decision uses the count including this cycle's M0 completion.
  assign cnt_inc = (m0_done && req[ARB_M_FETCH] && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  assign starve  = (cnt_inc == CNT_MAX);

  arb_pick u_pick (
    .req    (req),
    .starve (starve),
    .aux_en (AUX_ON),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rearb   = 1'b0;
    case (state_q)
      ARB_IDLE: rearb = 1'b1;
      ARB_OWN: begin
        if (done) begin
          if (own_lock) state_d = ARB_LOCKED;
          else          rearb   = 1'b1;
        end else if (!own_req) begin
          rearb = 1'b1;
        end
      end
      ARB_LOCKED: begin
        if (done) rearb = !own_lock;
        else      rearb = !own_req && !own_lock;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = ARB_NONE;
      end
    endcase
    if (rearb) begin
      grant_d = winner;
      state_d = (winner == ARB_NONE) ? ARB_IDLE : ARB_OWN;
    end
    cnt_d = (rearb && (winner == ARB_M_FETCH)) ? '0 : cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= ARB_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant          = grant_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = cnt_q;

endmodule
